rle_decoder: RTL and testbench

RLE_DECODER -- requirements
Module: rle_decoder

---
 rtl/rle_decoder_if.sv | 24 ++
 rtl/rle_decoder.sv | 196 +++++++++++++++++++
 tb/tb_rle_decoder.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rle_decoder_if.sv
// Memory port A bundle between the RLE decoder (master) and a single-port synchronous RAM (slave).
interface rle_decoder_if;
    logic        port_A_clk;
    logic [31:0] port_A_data_in;
    logic [31:0] port_A_data_out;
    logic [15:0] port_A_addr;
    logic        port_A_we;

    modport master (
        output port_A_clk,
        output port_A_data_in,
        output port_A_addr,
        output port_A_we,
        input  port_A_data_out
    );

    modport slave (
        input  port_A_clk,
        input  port_A_data_in,
        input  port_A_addr,
        input  port_A_we,
        output port_A_data_out
    );
endinterface

// File: rtl/rle_decoder.sv
// Run-length decoder: reads (symbol, count) byte pairs from memory and writes the expanded
// byte stream back as little-endian 32-bit words through the shared memory port.
module rle_decoder (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [31:0]   rle_addr,
    input  logic [31:0]   rle_size,
    input  logic [31:0]   message_addr,
    output logic [31:0]   message_size,
    output logic          done,
    rle_decoder_if.master port_a
);

    typedef enum logic [2:0] {
        StIdle, StRdReq, StRdWait, StExpand, StWr, StFlush, StDone
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] src_q, src_d;
    logic [31:0] len_q, len_d;
    logic [31:0] dst_q, dst_d;
    logic [31:0] bi_q, bi_d;
    logic [31:0] word_q, word_d;
    logic        wv_q, wv_d;
    logic [7:0]  sym_q, sym_d;
    logic        have_sym_q, have_sym_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] asm_q, asm_d;
    logic [2:0]  asm_n_q, asm_n_d;
    logic [31:0] wr_n_q, wr_n_d;
    logic [31:0] size_q, size_d;

    logic        in_end;
    logic        run_end;
    logic [7:0]  cur_byte;
    logic [31:0] addr_full;
    logic        addr_unused;

    // in_end: every whole pair has been parsed; a trailing odd byte is never consumed
    assign in_end   = (bi_q >= len_q);
    assign run_end  = (cnt_q == 8'd0) && in_end;
    assign cur_byte = word_q[{bi_q[1:0], 3'b000} +: 8];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) state_d = (rle_size < 32'd2) ? StFlush : StRdReq;
            end
            StRdReq:  state_d = StRdWait;
            StRdWait: state_d = StExpand;
            StExpand: begin
                if (cnt_q != 8'd0) begin
                    if (asm_n_q == 3'd3)                 state_d = StWr;
                    else if (cnt_q == 8'd1 && in_end)    state_d = StFlush;
                end else if (in_end) begin
                    state_d = (asm_n_q != 3'd0) ? StFlush : StDone;
                end else if (!wv_q) begin
                    state_d = StRdReq;
                end
            end
            StWr:     state_d = run_end ? StDone : StExpand;
            StFlush:  state_d = StDone;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        src_d      = src_q;
        len_d      = len_q;
        dst_d      = dst_q;
        bi_d       = bi_q;
        word_d     = word_q;
        wv_d       = wv_q;
        sym_d      = sym_q;
        have_sym_d = have_sym_q;
        cnt_d      = cnt_q;
        asm_d      = asm_q;
        asm_n_d    = asm_n_q;
        wr_n_d     = wr_n_q;
        size_d     = size_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    src_d      = rle_addr;
                    len_d      = {rle_size[31:1], 1'b0};
                    dst_d      = message_addr;
                    bi_d       = '0;
                    wv_d       = 1'b0;
                    have_sym_d = 1'b0;
                    cnt_d      = '0;
                    asm_d      = '0;
                    asm_n_d    = '0;
                    wr_n_d     = '0;
                    size_d     = '0;
                end
            end
            StRdWait: begin
                word_d = port_a.port_A_data_out;
                wv_d   = 1'b1;
            end
            StExpand: begin
                if (cnt_q != 8'd0) begin
                    asm_d[{asm_n_q[1:0], 3'b000} +: 8] = sym_q;
                    asm_n_d = asm_n_q + 3'd1;
                    cnt_d   = cnt_q - 8'd1;
                    size_d  = size_q + 32'd1;
                end else if (!in_end && wv_q) begin
                    // Symbol survives a word refill when its count sits in the next word
                    if (have_sym_q) begin
                        cnt_d      = cur_byte;
                        have_sym_d = 1'b0;
                    end else begin
                        sym_d      = cur_byte;
                        have_sym_d = 1'b1;
                    end
                    bi_d = bi_q + 32'd1;
                    if (bi_q[1:0] == 2'd3) wv_d = 1'b0;
                end
            end
            StWr, StFlush: begin
                if (asm_n_q != 3'd0) begin
                    asm_d   = '0;
                    asm_n_d = '0;
                    wr_n_d  = wr_n_q + 32'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q      <= '0;
            len_q      <= '0;
            dst_q      <= '0;
            bi_q       <= '0;
            word_q     <= '0;
            wv_q       <= 1'b0;
            sym_q      <= '0;
            have_sym_q <= 1'b0;
            cnt_q      <= '0;
            asm_q      <= '0;
            asm_n_q    <= '0;
            wr_n_q     <= '0;
            size_q     <= '0;
        end else begin
            src_q      <= src_d;
            len_q      <= len_d;
            dst_q      <= dst_d;
            bi_q       <= bi_d;
            word_q     <= word_d;
            wv_q       <= wv_d;
            sym_q      <= sym_d;
            have_sym_q <= have_sym_d;
            cnt_q      <= cnt_d;
            asm_q      <= asm_d;
            asm_n_q    <= asm_n_d;
            wr_n_q     <= wr_n_d;
            size_q     <= size_d;
        end
    end

    always_comb begin
        port_a.port_A_we      = 1'b0;
        port_a.port_A_data_in = '0;
        addr_full             = '0;
        unique case (state_q)
            StRdReq: addr_full = src_q + {bi_q[31:2], 2'b00};
            StWr, StFlush: begin
                if (asm_n_q != 3'd0) begin
                    port_a.port_A_we      = 1'b1;
                    port_a.port_A_data_in = asm_q;
                    addr_full             = dst_q + (wr_n_q << 2);
                end
            end
            default: ;
        endcase
    end

    assign port_a.port_A_addr = addr_full[15:0];
    assign port_a.port_A_clk  = clk;
    assign addr_unused        = ^addr_full[31:16];
    assign message_size       = size_q;
    assign done               = (state_q == StDone);

endmodule

// File: tb/tb_rle_decoder.sv
// Randomised bench for rle_decoder: a queue-based model predicts every memory write and the
// final buffer contents, with a few literal vectors pinning the model itself.
module tb_rle_decoder;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    localparam logic [31:0] SENT = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] rle_addr;
    logic [31:0] rle_size;
    logic [31:0] message_addr;
    logic [31:0] message_size;
    logic        done;

    rle_decoder_if bus ();

    always #5 clk = ~clk;

    rle_decoder dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rle_addr     (rle_addr),
        .rle_size     (rle_size),
        .message_addr (message_addr),
        .message_size (message_size),
        .done         (done),
        .port_a       (bus)
    );

    logic [31:0] mem [0:16383];

    always @(posedge bus.port_A_clk) begin
        bus.port_A_data_out <= mem[bus.port_A_addr[15:2]];
        if (bus.port_A_we) mem[bus.port_A_addr[15:2]] = bus.port_A_data_in;
    end

    int          checks = 0;
    int          errors = 0;
    int          wr_seen = 0;
    int          exp_size;
    logic [7:0]  stream [$];
    logic [31:0] exp_words [$];
    wr_t         exp_q [$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Every write the DUT issues must be the next one the model predicts
    always @(negedge clk) begin
        wr_t e;
        if (bus.port_A_we === 1'b1) begin
            wr_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write actual=%h@%h required=none",
                         bus.port_A_data_in, bus.port_A_addr);
            end else begin
                e = exp_q.pop_front();
                if (bus.port_A_addr !== e.addr || bus.port_A_data_in !== e.data) begin
                    errors++;
                    $display("FAIL write actual=%h@%h required=%h@%h",
                             bus.port_A_data_in, bus.port_A_addr, e.data, e.addr);
                end
            end
        end
    end

    task automatic load(input logic [31:0] src, input int size);
        for (int w = 0; w <= (size + 3) / 4; w++) mem[((src >> 2) + w) & 16383] = $urandom;
        for (int i = 0; i < size; i++)
            mem[((src >> 2) + i / 4) & 16383][8 * (i % 4) +: 8] = stream[i];
    endtask

    task automatic build_model(input int size, input logic [31:0] dst);
        logic [7:0]  ob [$];
        logic [31:0] wd;
        exp_words.delete();
        exp_q.delete();
        for (int k = 0; k < size / 2; k++)
            for (int c = 0; c < int'(stream[2 * k + 1]); c++) ob.push_back(stream[2 * k]);
        exp_size = ob.size();
        for (int w = 0; w * 4 < ob.size(); w++) begin
            wd = '0;
            for (int b = 0; b < 4; b++) if (w * 4 + b < ob.size()) wd[8 * b +: 8] = ob[w * 4 + b];
            exp_words.push_back(wd);
            exp_q.push_back({16'(dst + 32'(4 * w)), wd});
        end
        for (int w = 0; w < exp_words.size() + 2; w++) mem[((dst >> 2) + w) & 16383] = SENT;
    endtask

    task automatic run(input logic [31:0] src, input int size, input logic [31:0] dst,
                       input bit wiggle, input bit hold2);
        int bad;
        int cyc;
        bit ok;
        logic [31:0] sz;
        load(src, size);
        build_model(size, dst);
        @(negedge clk);
        rle_addr = src;
        rle_size = 32'(size);
        message_addr = dst;
        start = 1'b1;
        @(negedge clk);
        cyc = 1;
        if (hold2) begin
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
            if (wiggle && !done) start = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL done_timeout actual=0 required=1");
        end
        if (size < 2) check32("short_done_latency_le3", 32'(cyc <= 3), 32'd1);
        check32("message_size", message_size, 32'(exp_size));
        check32("writes_outstanding", 32'(exp_q.size()), 32'd0);
        bad = 0;
        for (int w = 0; w < exp_words.size(); w++)
            if (mem[((dst >> 2) + w) & 16383] !== exp_words[w]) bad++;
        check32("output_words_bad", 32'(bad), 32'd0);
        check32("guard_word", mem[((dst >> 2) + exp_words.size()) & 16383], SENT);
        sz = message_size;
        repeat (3) @(negedge clk);
        check32("done_held", {31'd0, done}, 32'd1);
        check32("size_held", message_size, sz);
    endtask

    task automatic set_stream(input logic [7:0] b [$]);
        stream = b;
    endtask

    initial begin
        logic [7:0] plain [$];
        logic [7:0] runsym [6];
        int         runlen [6];
        int         base;
        int         aborted;
        int         bad;
        int         np;

        for (int i = 0; i < 16384; i++) mem[i] = '0;
        reset = 1'b1;
        start = 1'b0;
        rle_addr = '0;
        rle_size = '0;
        message_addr = '0;
        repeat (2) @(negedge clk);
        check32("rst_done", {31'd0, done}, 32'd0);
        check32("rst_size", message_size, 32'd0);
        check32("rst_we", {31'd0, bus.port_A_we}, 32'd0);
        check32("rst_addr", {16'd0, bus.port_A_addr}, 32'd0);
        check32("rst_din", bus.port_A_data_in, 32'd0);
        reset = 1'b0;

        set_stream('{8'h41, 8'h05, 8'h42, 8'h03});
        run(32'hC8, 4, 32'h0, 1'b0, 1'b0);
        check32("lit_w0", mem[0], 32'h4141_4141);
        check32("lit_w1", mem[1], 32'h4242_4241);
        check32("lit_size8", message_size, 32'd8);

        set_stream('{8'h7F, 8'h06});
        run(32'hC8, 2, 32'h200, 1'b0, 1'b0);
        check32("flush_w0", mem[32'h200 >> 2], 32'h7F7F_7F7F);
        check32("flush_w1", mem[(32'h200 >> 2) + 1], 32'h0000_7F7F);
        check32("flush_size6", message_size, 32'd6);

        set_stream('{8'h41, 8'h00, 8'h42, 8'hFF, 8'h43, 8'h01});
        base = wr_seen;
        run(32'hC8, 6, 32'h400, 1'b0, 1'b0);
        check32("straddle_size", message_size, 32'd256);
        check32("straddle_nwr", 32'(wr_seen - base), 32'd64);
        check32("straddle_last", mem[(32'h400 >> 2) + 63], 32'h4342_4242);

        set_stream('{});
        base = wr_seen;
        run(32'hC8, 0, 32'h600, 1'b0, 1'b0);
        set_stream('{8'h33});
        run(32'hC8, 1, 32'h600, 1'b0, 1'b1);
        check32("short_nwr", 32'(wr_seen - base), 32'd0);
        check32("short_size0", message_size, 32'd0);

        // Abort mid-expand, then restart the same job from scratch
        set_stream('{8'h55, 8'hFF, 8'h66, 8'h0A});
        load(32'h300, 4);
        build_model(4, 32'h2000);
        base = wr_seen;
        @(negedge clk);
        rle_addr = 32'h300;
        rle_size = 32'd4;
        message_addr = 32'h2000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        reset = 1'b1;
        #1;
        check32("abort_done", {31'd0, done}, 32'd0);
        check32("abort_we", {31'd0, bus.port_A_we}, 32'd0);
        check32("abort_size", message_size, 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        aborted = wr_seen - base;
        repeat (5) @(negedge clk);
        check32("abort_no_more_wr", 32'(wr_seen - base), 32'(aborted));
        bad = 0;
        for (int w = aborted; w < exp_words.size() + 2; w++)
            if (mem[(32'h2000 >> 2) + w] !== SENT) bad++;
        check32("abort_untouched", 32'(bad), 32'd0);
        run(32'h300, 4, 32'h2000, 1'b0, 1'b0);

        // Round trip: plaintext at 0x0, encoded pairs at 0xC8, decoded to 0x190
        runsym = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        runlen = '{10, 3, 7, 12, 1, 15};
        plain.delete();
        stream.delete();
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < runlen[r]; c++) plain.push_back(runsym[r]);
            stream.push_back(runsym[r]);
            stream.push_back(8'(runlen[r]));
        end
        for (int i = 0; i < 48; i++) mem[i / 4][8 * (i % 4) +: 8] = plain[i];
        base = wr_seen;
        run(32'hC8, 12, 32'h190, 1'b0, 1'b1);
        bad = 0;
        for (int w = 0; w < 12; w++) if (mem[(32'h190 >> 2) + w] !== mem[w]) bad++;
        check32("roundtrip_bad", 32'(bad), 32'd0);
        check32("roundtrip_size", message_size, 32'd48);
        check32("roundtrip_nwr", 32'(wr_seen - base), 32'd12);

        for (int t = 0; t < 16; t++) begin
            np = $urandom_range(0, 7);
            stream.delete();
            for (int k = 0; k < np; k++) begin
                stream.push_back(8'($urandom));
                if ($urandom_range(0, 3) == 0)      stream.push_back(8'h00);
                else if ($urandom_range(0, 9) == 0) stream.push_back(8'hFF);
                else                                stream.push_back(8'($urandom_range(1, 40)));
            end
            if ($urandom_range(0, 1) == 1) stream.push_back(8'($urandom));
            run(32'h100 + 32'(4 * $urandom_range(0, 63)), stream.size(),
                32'h4000 + 32'(4 * $urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
